// File: rtl/axi_lite_cmd_master_if.sv
// axi_lite_cmd_master_if: AXI4-Lite bus between the command master and a register-block slave
interface axi_lite_cmd_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   AWADDR;
    logic [2:0]          AWPROT;
    logic                AWVALID;
    logic                AWREADY;
    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WVALID;
    logic                WREADY;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;
    logic [ADDR_W-1:0]   ARADDR;
    logic [2:0]          ARPROT;
    logic                ARVALID;
    logic                ARREADY;
    logic [DATA_W-1:0]   RDATA;
    logic [1:0]          RRESP;
    logic                RVALID;
    logic                RREADY;

    modport master (
        output AWADDR, AWPROT, AWVALID, input AWREADY,
        output WDATA, WSTRB, WVALID, input WREADY,
        input BRESP, BVALID, output BREADY,
        output ARADDR, ARPROT, ARVALID, input ARREADY,
        input RDATA, RRESP, RVALID, output RREADY
    );

    modport slave (
        input AWADDR, AWPROT, AWVALID, output AWREADY,
        input WDATA, WSTRB, WVALID, output WREADY,
        output BRESP, BVALID, input BREADY,
        input ARADDR, ARPROT, ARVALID, output ARREADY,
        output RDATA, RRESP, RVALID, input RREADY
    );
endinterface

// File: rtl/axi_lite_cmd_master.sv
// axi_lite_cmd_master: single-outstanding AXI4-Lite master driven by a valid/ready command stream
module axi_lite_cmd_master #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_timeout,
    output logic                  busy,
    axi_lite_cmd_master_if.master M_AXI
);
    typedef enum logic [2:0] {IDLE, WR, WB, RA, RD, RSP} state_t;

    localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic                awvalid_q;
    logic                wvalid_q;
    logic                bready_q;
    logic                arvalid_q;
    logic                rready_q;
    logic                aw_done_q;
    logic                w_done_q;
    logic                rsp_valid_q;
    logic                rsp_timeout_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic [1:0]          rsp_resp_q;
    logic [31:0]         wd_q;
    logic                aw_done_d;
    logic                w_done_d;
    logic                wd_fire;
    logic                abort;

    assign cmd_ready     = state_q == IDLE;
    assign busy          = state_q != IDLE;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign rsp_timeout   = rsp_timeout_q;
    assign M_AXI.AWADDR  = addr_q;
    assign M_AXI.ARADDR  = addr_q;
    assign M_AXI.AWPROT  = 3'b000;
    assign M_AXI.ARPROT  = 3'b000;
    assign M_AXI.WDATA   = wdata_q;
    assign M_AXI.WSTRB   = wstrb_q;
    assign M_AXI.AWVALID = awvalid_q;
    assign M_AXI.WVALID  = wvalid_q;
    assign M_AXI.BREADY  = bready_q;
    assign M_AXI.ARVALID = arvalid_q;
    assign M_AXI.RREADY  = rready_q;

    // Sticky AW/W completion including this cycle's handshake; watchdog abort unless a B/R beat completes now
    always_comb begin
        aw_done_d = aw_done_q | (awvalid_q & M_AXI.AWREADY);
        w_done_d  = w_done_q | (wvalid_q & M_AXI.WREADY);
        wd_fire   = (TIMEOUT_CYCLES != 0) && (wd_q == WD_LAST);
        abort     = wd_fire && (state_q == WR || state_q == RA ||
                    (state_q == WB && !M_AXI.BVALID) || (state_q == RD && !M_AXI.RVALID));
    end

    // Transaction sequencer with registered AXI handshake and response outputs
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= 2'b00;
            wd_q          <= '0;
        end else begin
            if (state_q inside {WR, WB, RA, RD}) wd_q <= wd_q + {31'd0, ~&wd_q};
            if (abort) begin
                awvalid_q     <= 1'b0;
                wvalid_q      <= 1'b0;
                bready_q      <= 1'b0;
                arvalid_q     <= 1'b0;
                rready_q      <= 1'b0;
                rsp_valid_q   <= 1'b1;
                rsp_resp_q    <= 2'b10;
                rsp_timeout_q <= 1'b1;
                rsp_rdata_q   <= '0;
                state_q       <= RSP;
            end else begin
                case (state_q)
                    IDLE: if (cmd_valid) begin
                        addr_q        <= cmd_addr;
                        wdata_q       <= cmd_wdata;
                        wstrb_q       <= cmd_wstrb;
                        wd_q          <= '0;
                        rsp_timeout_q <= 1'b0;
                        aw_done_q     <= 1'b0;
                        w_done_q      <= 1'b0;
                        awvalid_q     <= cmd_write;
                        wvalid_q      <= cmd_write;
                        arvalid_q     <= !cmd_write;
                        state_q       <= cmd_write ? WR : RA;
                    end
                    WR: begin
                        aw_done_q <= aw_done_d;
                        w_done_q  <= w_done_d;
                        if (aw_done_d) awvalid_q <= 1'b0;
                        if (w_done_d) wvalid_q <= 1'b0;
                        if (aw_done_d && w_done_d) begin
                            bready_q <= 1'b1;
                            state_q  <= WB;
                        end
                    end
                    WB: if (M_AXI.BVALID) begin
                        bready_q    <= 1'b0;
                        rsp_resp_q  <= M_AXI.BRESP;
                        rsp_rdata_q <= '0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RSP;
                    end
                    RA: if (M_AXI.ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= RD;
                    end
                    RD: if (M_AXI.RVALID) begin
                        rready_q    <= 1'b0;
                        rsp_rdata_q <= M_AXI.RDATA;
                        rsp_resp_q  <= M_AXI.RRESP;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RSP;
                    end
                    RSP: if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/axi_lite_cmd_master.md
Name: axi_lite_cmd_master

Overview:
Single-outstanding AXI4-Lite master that turns a simple valid/ready command stream into AXI4-Lite read and write transactions.
It sits directly upstream of the register block's slave port and drives its AXI bus, which exposes the RO, WO, WOE, ROC, RWS, RWCR, RWCW and RWA registers.
Responses (read data, RESP code, timeout flag) come back on a valid/ready response stream.
A watchdog aborts transactions the slave never completes, so a hung decode cannot stall the sequencer.

Parameters:
ADDR_W, 32, address width of cmd_addr and M_AXI_AWADDR/ARADDR.
DATA_W, 32, data width; DATA_W/8 strobe bits.
TIMEOUT_CYCLES, 1024, watchdog limit in ACLK cycles; 0 disables the watchdog.

Ports:
ACLK  in  1  sole clock.
ARESETN  in  1  asynchronous active-low reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  command accepted this cycle when cmd_valid=1.
cmd_write  in  1  1=write, 0=read.
cmd_addr  in  ADDR_W  byte address.
cmd_wdata  in  DATA_W  write data (ignored for reads).
cmd_wstrb  in  DATA_W/8  write strobes (ignored for reads).
rsp_valid  out  1  response present.
rsp_ready  in  1  response consumed.
rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts.
rsp_resp  out  2  captured BRESP/RRESP; 2'b10 on timeout.
rsp_timeout  out  1  watchdog fired for this transaction.
busy  out  1  high in any state other than IDLE.
M_AXI_AWADDR/AWVALID/AWREADY, M_AXI_WDATA/WSTRB/WVALID/WREADY, M_AXI_BRESP/BVALID/BREADY, M_AXI_ARADDR/ARVALID/ARREADY, M_AXI_RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master side, widths per ADDR_W/DATA_W. AWPROT/ARPROT tied to 3'b000.

Behaviour:
- Reset (ARESETN low, async):
  - State is IDLE.
  - All AXI VALID/READY outputs are 0; rsp_valid=0, rsp_timeout=0, rsp_resp=0, rsp_rdata=0; busy=0; watchdog counter is 0.
  - Address/data registers reset to 0.
- States: IDLE, WR (AW/W phase), WB (B phase), RA (AR phase), RD (R phase), RSP.
- IDLE:
  - cmd_ready=1 combinationally from state; it is 0 in every other state.
  - On cmd_valid&cmd_ready, register addr/wdata/wstrb, clear the watchdog, and go to WR (cmd_write=1) or RA (cmd_write=0).
- WR:
  - AWVALID and WVALID assert in the cycle after acceptance (1-cycle latency).
  - Each deasserts independently on its own handshake, in any order or simultaneously; two sticky done flags track completion.
  - When both are done, go to WB. BREADY must not be asserted before both handshakes complete.
- WB: BREADY=1. On BVALID, capture BRESP, set rsp_rdata=0, go to RSP.
- RA: ARVALID=1 until ARREADY, then go to RD.
- RD: RREADY=1. On RVALID, capture RDATA/RRESP, go to RSP.
- RSP:
  - rsp_valid=1; the response fields are held stable until rsp_ready.
  - On rsp_valid&rsp_ready, return to IDLE. The next command can be accepted the cycle after.
- Minimum command-to-response latency with an always-ready slave:
  - Write: 3 cycles (AW/W, B, rsp_valid).
  - Read: 3 cycles (AR, R, rsp_valid).
- VALID signals, once asserted, never drop before their handshake, except on watchdog abort or reset.
- Addresses and data stay stable while their VALID is high.
- Watchdog:
  - The counter increments every cycle in WR/WB/RA/RD and saturates.
  - When TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES, deassert all AXI VALID/READY that cycle and go to RSP with rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=0.
  - If the watchdog fires on the same cycle as the completing handshake (BVALID/RVALID), the real response wins and there is no timeout.
  - Abort is a debug recovery: any late B/R beat from the slave is ignored (READY stays low), and the slave is not reset by this block.
- rsp_timeout is cleared when the next command is accepted.
- No address alignment checks; cmd_addr is passed through unchanged.

Test Plan:
- Write, always-ready slave: cmd write addr=0x0000_0010, wdata=0xA5A5_1234, wstrb=0xF. Required: AW/W handshake in cycle 1, BREADY in cycle 2, rsp_valid in cycle 3 with resp=00, rdata=0, timeout=0.
- Skewed write handshakes: WREADY 2 cycles before AWREADY, then the reverse, then simultaneous. Required: each VALID drops only on its own handshake; BREADY rises only after both; slave captures 0xA5A5_1234 each time.
- Read: cmd read addr=0x0000_0004; slave returns RDATA=0xDEAD_BEEF, RRESP=00 after a 4-cycle RVALID delay. Required: rsp_rdata=0xDEAD_BEEF, resp=00; RREADY held high throughout.
- Error and backpressure: slave returns BRESP=2'b10 and rsp_ready is held low 5 cycles. Required: rsp_valid and resp=10 stable for all 5 cycles; cmd_ready=0 until the cycle after rsp_ready.
- Timeout: TIMEOUT_CYCLES=8, slave never asserts ARREADY. Required: ARVALID drops after 8 cycles in RA; rsp_resp=10, rsp_timeout=1, rsp_rdata=0; the next read to a responsive slave completes with timeout=0.
- Reset mid-transaction: ARESETN low while in WB. Required: immediately BREADY=0, rsp_valid=0, busy=0, state IDLE; after release a fresh write completes normally.
